seg7_readback_monitor: RTL and testbench



---
 rtl/seg7_readback_monitor.sv | 245 ++++++++++++++++++++++++
 tb/tb_seg7_readback_monitor.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/seg7_readback_monitor.sv
// ---------------------------------------------------------------------------
// seg7_readback_monitor
//
// Purpose:
//   Watches the active-low segment drive of a 7-segment HEX digit and
//   decodes it back to a BCD value. Each pattern must be stable for
//   STABLE_CYCLES samples before it is accepted. Accepted changes are
//   classified as step up, step down, jump, blank or invalid. This lets a
//   board check its own display output.
//
// Optional feature (macro SEG7_MON_DP_EN):
//   When defined, seg_in widens to 8 bits. Bit 7 is the active-low decimal
//   point. The dp output reports the decimal point of the last accepted
//   pattern.
//
// Ports:
//   clk          in   system clock
//   rst          in   asynchronous active-high reset
//   seg_in       in   active-low segments, bit0=a .. bit6=g (bit7=dp opt.)
//   digit        out  last accepted digit (BCD)
//   digit_valid  out  level, last accepted pattern was a legal digit
//   digit_strobe out  pulse, new digit accepted
//   step_up      out  pulse, new digit = previous + 1 (mod 10)
//   step_down    out  pulse, new digit = previous - 1 (mod 10)
//   step_jump    out  pulse, digit changed by any other amount
//   blank        out  level, last accepted pattern was all segments off
//   err_pulse    out  pulse, invalid pattern accepted
//   err_count    out  saturating count of accepted invalid patterns
//   dp           out  (SEG7_MON_DP_EN only) decimal point, active-high
// ---------------------------------------------------------------------------
module seg7_readback_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
`ifdef SEG7_MON_DP_EN
    input  logic [7:0]           seg_in,
    output logic                 dp,
`else
    input  logic [6:0]           seg_in,
`endif
    output logic [3:0]           digit,
    output logic                 digit_valid,
    output logic                 digit_strobe,
    output logic                 step_up,
    output logic                 step_down,
    output logic                 step_jump,
    output logic                 blank,
    output logic                 err_pulse,
    output logic [ERR_CNT_W-1:0] err_count
);

`ifdef SEG7_MON_DP_EN
    localparam int SEG_W = 8;
`else
    localparam int SEG_W = 7;
`endif
    localparam logic [7:0] STABLE_L = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_NONE,
        ST_DIGIT,
        ST_BLANK,
        ST_INVALID
    } lastState_t;

    logic [SEG_W-1:0]     seg_q, lastPat_q, lastPat_d;
    logic [7:0]           runLen_q, runLen_d;
    logic                 accepted_q, accepted_d;
    logic                 lastPatValid_q, lastPatValid_d;
    lastState_t           lastState_q, lastState_d;
    logic [3:0]           digit_q, digit_d;
    logic                 digitValid_q, digitValid_d;
    logic                 digitStrobe_q, digitStrobe_d;
    logic                 stepUp_q, stepUp_d;
    logic                 stepDown_q, stepDown_d;
    logic                 stepJump_q, stepJump_d;
    logic                 blank_q, blank_d;
    logic                 errPulse_q, errPulse_d;
    logic [ERR_CNT_W-1:0] errCount_q, errCount_d;
`ifdef SEG7_MON_DP_EN
    logic                 dp_q, dp_d;
`endif

    logic       sameSample, accept, newPattern;
    logic       decIsDigit, decIsBlank;
    logic [3:0] decDigit, upOfLast, downOfLast;

    // Decode the sampled segment pattern (bits 6:0 only) into a digit.
    always_comb begin
        decIsDigit = 1'b1;
        decIsBlank = 1'b0;
        decDigit   = 4'd0;
        case (seg_q[6:0])
            7'b100_0000: decDigit = 4'd0;
            7'b111_1001: decDigit = 4'd1;
            7'b010_0100: decDigit = 4'd2;
            7'b011_0000: decDigit = 4'd3;
            7'b001_1001: decDigit = 4'd4;
            7'b001_0010: decDigit = 4'd5;
            7'b000_0010: decDigit = 4'd6;
            7'b111_1000: decDigit = 4'd7;
            7'b000_0000: decDigit = 4'd8;
            7'b001_0000: decDigit = 4'd9;
            7'b111_1111: begin
                decIsDigit = 1'b0;
                decIsBlank = 1'b1;
            end
            default:     decIsDigit = 1'b0;
        endcase
    end

    // Run-length tracking. A run counts identical consecutive samples and
    // is allowed to fire acceptance only once. The accepted pattern is the
    // one held in seg_q, so a change arriving on the same edge still lets
    // the completed run be reported.
    always_comb begin
        sameSample = (seg_in == seg_q);
        if (!sameSample)
            runLen_d = 8'd1;
        else if (runLen_q == STABLE_L)
            runLen_d = STABLE_L;
        else
            runLen_d = runLen_q + 8'd1;
        accept     = (runLen_q == STABLE_L) && !accepted_q;
        accepted_d = sameSample ? (accepted_q | accept) : 1'b0;
        newPattern = accept && !(lastPatValid_q && (lastPat_q == seg_q));
        upOfLast   = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        downOfLast = (digit_q == 4'd0) ? 4'd9 : digit_q - 4'd1;
    end

    // Classification of a newly accepted pattern. Pulses default low every
    // cycle and levels hold, so a discarded repeat leaves everything alone.
    always_comb begin
        lastPat_d      = lastPat_q;
        lastPatValid_d = lastPatValid_q;
        lastState_d    = lastState_q;
        digit_d        = digit_q;
        digitValid_d   = digitValid_q;
        blank_d        = blank_q;
        errCount_d     = errCount_q;
        digitStrobe_d  = 1'b0;
        stepUp_d       = 1'b0;
        stepDown_d     = 1'b0;
        stepJump_d     = 1'b0;
        errPulse_d     = 1'b0;
`ifdef SEG7_MON_DP_EN
        dp_d           = dp_q;
`endif
        if (newPattern) begin
            lastPat_d      = seg_q;
            lastPatValid_d = 1'b1;
`ifdef SEG7_MON_DP_EN
            dp_d           = ~seg_q[7];
`endif
            if (decIsDigit) begin
                digit_d       = decDigit;
                digitValid_d  = 1'b1;
                blank_d       = 1'b0;
                digitStrobe_d = 1'b1;
                lastState_d   = ST_DIGIT;
                // Same digit can only reappear here when just the decimal
                // point changed; that is a strobe without any step.
                if (lastState_q == ST_DIGIT) begin
                    if (decDigit == upOfLast)
                        stepUp_d = 1'b1;
                    else if (decDigit == downOfLast)
                        stepDown_d = 1'b1;
                    else if (decDigit != digit_q)
                        stepJump_d = 1'b1;
                end
            end else if (decIsBlank) begin
                blank_d      = 1'b1;
                digitValid_d = 1'b0;
                lastState_d  = ST_BLANK;
            end else begin
                errPulse_d   = 1'b1;
                digitValid_d = 1'b0;
                blank_d      = 1'b0;
                lastState_d  = ST_INVALID;
                if (errCount_q != {ERR_CNT_W{1'b1}})
                    errCount_d = errCount_q + 1'b1;
            end
        end
    end

    // State register; reset clears the sampler so the pattern present
    // after release is qualified from scratch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_q          <= '0;
            runLen_q       <= '0;
            accepted_q     <= 1'b0;
            lastPat_q      <= '0;
            lastPatValid_q <= 1'b0;
            lastState_q    <= ST_NONE;
            digit_q        <= '0;
            digitValid_q   <= 1'b0;
            digitStrobe_q  <= 1'b0;
            stepUp_q       <= 1'b0;
            stepDown_q     <= 1'b0;
            stepJump_q     <= 1'b0;
            blank_q        <= 1'b0;
            errPulse_q     <= 1'b0;
            errCount_q     <= '0;
`ifdef SEG7_MON_DP_EN
            dp_q           <= 1'b0;
`endif
        end else begin
            seg_q          <= seg_in;
            runLen_q       <= runLen_d;
            accepted_q     <= accepted_d;
            lastPat_q      <= lastPat_d;
            lastPatValid_q <= lastPatValid_d;
            lastState_q    <= lastState_d;
            digit_q        <= digit_d;
            digitValid_q   <= digitValid_d;
            digitStrobe_q  <= digitStrobe_d;
            stepUp_q       <= stepUp_d;
            stepDown_q     <= stepDown_d;
            stepJump_q     <= stepJump_d;
            blank_q        <= blank_d;
            errPulse_q     <= errPulse_d;
            errCount_q     <= errCount_d;
`ifdef SEG7_MON_DP_EN
            dp_q           <= dp_d;
`endif
        end
    end

    assign digit        = digit_q;
    assign digit_valid  = digitValid_q;
    assign digit_strobe = digitStrobe_q;
    assign step_up      = stepUp_q;
    assign step_down    = stepDown_q;
    assign step_jump    = stepJump_q;
    assign blank        = blank_q;
    assign err_pulse    = errPulse_q;
    assign err_count    = errCount_q;
`ifdef SEG7_MON_DP_EN
    assign dp           = dp_q;
`endif

endmodule

// File: tb/tb_seg7_readback_monitor.sv
// ---------------------------------------------------------------------------
// tb_seg7_readback_monitor
//
// Directed bench for seg7_readback_monitor. A main instance (8-bit error
// counter) and a second instance with a 2-bit error counter share clock,
// reset and segment input, so the saturating counter can be observed on
// the same stimulus.
// ---------------------------------------------------------------------------
module tb_seg7_readback_monitor;

    localparam logic [6:0] P0 = 7'b100_0000;
    localparam logic [6:0] P1 = 7'b111_1001;
    localparam logic [6:0] P2 = 7'b010_0100;
    localparam logic [6:0] P3 = 7'b011_0000;
    localparam logic [6:0] P4 = 7'b001_1001;
    localparam logic [6:0] P5 = 7'b001_0010;
    localparam logic [6:0] P6 = 7'b000_0010;
    localparam logic [6:0] P7 = 7'b111_1000;
    localparam logic [6:0] P9 = 7'b001_0000;
    localparam logic [6:0] PB = 7'b111_1111;
    localparam logic [6:0] PA = 7'b000_1000;
    localparam logic [6:0] PX = 7'b000_0011;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] seg = PB;

    logic [3:0] digit, digit2;
    logic       digitValid, digitStrobe, stepUp, stepDown, stepJump;
    logic       blank, errPulse;
    logic       digitValid2, digitStrobe2, stepUp2, stepDown2, stepJump2;
    logic       blank2, errPulse2;
    logic [7:0] errCount;
    logic [1:0] errCount2;

    int total = 0;
    int bad   = 0;

    // Decimal point held off (active-low high) when the option is built in.
`ifdef SEG7_MON_DP_EN
    logic [7:0] segBus;
    logic       dp1, dp2;
    assign segBus = {1'b1, seg};
`else
    logic [6:0] segBus;
    assign segBus = seg;
`endif

    always #5 clk = ~clk;

    seg7_readback_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .seg_in(segBus),
`ifdef SEG7_MON_DP_EN
        .dp(dp1),
`endif
        .digit(digit), .digit_valid(digitValid), .digit_strobe(digitStrobe),
        .step_up(stepUp), .step_down(stepDown), .step_jump(stepJump),
        .blank(blank), .err_pulse(errPulse), .err_count(errCount)
    );

    seg7_readback_monitor #(.STABLE_CYCLES(4), .ERR_CNT_W(2)) dut2 (
        .clk(clk), .rst(rst), .seg_in(segBus),
`ifdef SEG7_MON_DP_EN
        .dp(dp2),
`endif
        .digit(digit2), .digit_valid(digitValid2), .digit_strobe(digitStrobe2),
        .step_up(stepUp2), .step_down(stepDown2), .step_jump(stepJump2),
        .blank(blank2), .err_pulse(errPulse2), .err_count(errCount2)
    );

    // One comparison: count it, and report tag/observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [6:0] pattern, input int cycles);
        seg = pattern;
        repeat (cycles) tick();
    endtask

    // Hold a pattern; nothing may change after 4 edges, the result appears
    // after the 5th (first sample + STABLE_CYCLES) and pulses end one later.
    task automatic expectAccept(input string tag, input logic [6:0] pattern,
                                input logic [3:0] expDigit, input logic expValid,
                                input logic expStrobe, input logic expUp,
                                input logic expDown, input logic expJump,
                                input logic expBlank, input logic expErr,
                                input logic [7:0] expCnt);
        applyStimulus(pattern, 4);
        checkOutput({tag, ".early"}, {27'd0, digitStrobe, stepUp, stepDown, stepJump, errPulse}, 32'd0);
        tick();
        checkOutput({tag, ".digit"}, {28'd0, digit}, {28'd0, expDigit});
        checkOutput({tag, ".valid"}, {31'd0, digitValid}, {31'd0, expValid});
        checkOutput({tag, ".pulses"}, {27'd0, digitStrobe, stepUp, stepDown, stepJump, errPulse},
                    {27'd0, expStrobe, expUp, expDown, expJump, expErr});
        checkOutput({tag, ".blank"}, {31'd0, blank}, {31'd0, expBlank});
        checkOutput({tag, ".errcnt"}, {24'd0, errCount}, {24'd0, expCnt});
        tick();
        checkOutput({tag, ".pulse_end"}, {27'd0, digitStrobe, stepUp, stepDown, stepJump, errPulse}, 32'd0);
    endtask

    initial begin
        $display("[TB] start");

        // Reset state.
        tick();
        tick();
        checkOutput("rst.digit", {28'd0, digit}, 32'd0);
        checkOutput("rst.levels", {30'd0, digitValid, blank}, 32'd0);
        checkOutput("rst.pulses", {27'd0, digitStrobe, stepUp, stepDown, stepJump, errPulse}, 32'd0);
        checkOutput("rst.errcnt", {24'd0, errCount}, 32'd0);
        checkOutput("rst.errcnt2", {30'd0, errCount2}, 32'd0);

        // First digit after reset: strobe only, no step.
        rst = 1'b0;
        expectAccept("first0", P0, 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAccept("up0to1", P1, 4'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAccept("jump1to9", P9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        expectAccept("up9to0", P0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAccept("down0to9", P9, 4'd9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAccept("jump9to3", P3, 4'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);

        // A 3-cycle glitch to 7, then back to 3: invisible, and the
        // re-accepted 3 is discarded as a repeat.
        applyStimulus(P7, 3);
        seg = P3;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("glitch.pulses", {27'd0, digitStrobe, stepUp, stepDown, stepJump, errPulse}, 32'd0);
            checkOutput("glitch.digit", {28'd0, digit}, 32'd3);
        end

        expectAccept("down3to2", P2, 4'd2, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
        expectAccept("jump2to6", P6, 4'd6, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0);
        expectAccept("invalidA", PA, 4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd1);
        expectAccept("afterInv5", P5, 4'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);
        expectAccept("blank", PB, 4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd1);
        expectAccept("afterBlank4", P4, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

        // Saturation: five alternating invalid patterns after a reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            expectAccept("sat", (i % 2 == 0) ? PA : PX, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0,
                         1'b0, 1'b0, 1'b1, 8'(i + 1));
            checkOutput("sat.errcnt2", {30'd0, errCount2}, (i >= 2) ? 32'd3 : 32'(i + 1));
        end

        expectAccept("afterSat4", P4, 4'd4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd5);

        // Asynchronous reset at run length 3 of a new digit 7.
        applyStimulus(P7, 3);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async.digit", {28'd0, digit}, 32'd0);
        checkOutput("async.valid", {31'd0, digitValid}, 32'd0);
        checkOutput("async.errcnt", {24'd0, errCount}, 32'd0);
        checkOutput("async.errcnt2", {30'd0, errCount2}, 32'd0);
        tick();
        rst = 1'b0;
        expectAccept("after_rst7", P7, 4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
